instr_fetch_unit: RTL and testbench

- CPU-side initiator for the combinational instruction-memory port: drives instr_address and samples instr_readdata.
- Holds the PC and emits one registered instruction per enabled cycle to decode.
- Handles the MIPS branch-delay-slot redirect and the halt convention (jump to address 0).
- Sits between the instruction RAM and the decode stage of the MIPS core.

---
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's two buses: the combinational instruction-RAM port
// and the fetch/decode hand-off (emitted instruction plus the redirect path
// coming back from decode).
//   master (fetch unit): drives instr_address, instr_out, pc_out, instr_valid;
//                        samples instr_readdata, redirect_valid, redirect_target
//   slave  (RAM/decode): the mirror image
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  // Instruction RAM port
  logic [XLEN-1:0] instr_address;
  logic [XLEN-1:0] instr_readdata;

  // Decode hand-off
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic            instr_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output instr_address,
    input  instr_readdata,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    input  instr_address,
    output instr_readdata,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output redirect_valid,
    output redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Holds the PC, fetches from a combinational instruction RAM and hands one
// registered instruction per enabled cycle to decode. Implements the MIPS
// branch-delay-slot redirect and the halt convention (redirect to HALT_ADDR).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   clk_enable   stall control; 0 freezes every register
//   bus          instr_fetch_unit_if.master (RAM port + decode hand-off)
//   active       1 until a halt (or alignment fault) has completed
//   align_fault  misaligned redirect seen (0 unless IFU_ALIGN_CHECK_EN)
//   fetch_count  instructions emitted since reset, wraps at 2^32
//
// Build option:
//   IFU_ALIGN_CHECK_EN  defined: a redirect target with [1:0]!=0 emits the
//                       delay slot, then parks in FAULT with align_fault=1.
//                       undefined: target[1:0] is forced to 00 when loaded.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_enable,
  instr_fetch_unit_if.master        bus,
  output logic                      active,
  output logic                      align_fault,
  output logic [31:0]               fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] CNT_STEP  = XLEN'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] instr_q,  instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q,  valid_d;
  logic            active_q, active_d;
  logic [XLEN-1:0] count_q,  count_d;
  logic            take_redirect;

`ifdef IFU_ALIGN_CHECK_EN
  logic            fault_q,  fault_d;
`endif

  // State and datapath registers; everything holds unless the comb block
  // says otherwise, so stalls need no special case here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      count_q  <= '0;
`ifdef IFU_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      count_q  <= count_d;
`ifdef IFU_ALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    active_d      = active_q;
    count_d       = count_q;
    // A redirect is only meaningful once decode holds a real instruction;
    // the fetch at pc this cycle is that branch's delay slot.
    take_redirect = bus.redirect_valid && valid_q;
`ifdef IFU_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif

    if (clk_enable) begin
      case (state_q)
        ST_RUN: begin
          instr_d  = bus.instr_readdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          count_d  = count_q + CNT_STEP;
          if (take_redirect) begin
            if (bus.redirect_target == HALT_ADDR) begin
              state_d = ST_HALTED;
`ifdef IFU_ALIGN_CHECK_EN
            end else if (bus.redirect_target[1:0] != 2'b00) begin
              state_d = ST_FAULT;
`endif
            end else begin
              pc_d = {bus.redirect_target[XLEN-1:2], 2'b00};
            end
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end

        ST_HALTED: begin
          // Retire the last delay slot; then nothing changes until reset.
          valid_d  = 1'b0;
          active_d = 1'b0;
        end

`ifdef IFU_ALIGN_CHECK_EN
        ST_FAULT: begin
          valid_d  = 1'b0;
          active_d = 1'b0;
          fault_d  = 1'b1;
        end
`endif

        default: begin
          // Unreachable encoding: park frozen like a halt.
          valid_d  = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_address = pc_q;
  assign bus.instr_out     = instr_q;
  assign bus.pc_out        = pc_out_q;
  assign bus.instr_valid   = valid_q;
  assign active            = active_q;
  assign fetch_count       = count_q;

`ifdef IFU_ALIGN_CHECK_EN
  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with directed scenarios and a randomized stream,
// comparing every cycle against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam logic [31:0] HALTA = 32'h00000000;

  typedef logic [130:0] snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic        align_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_VECTOR(RV),
    .HALT_ADDR   (HALTA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus),
    .active     (active),
    .align_fault(align_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // RAM contents: word i above the reset vector holds 0x8C000000+i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C000000 + ((a - RV) >> 2);
  endfunction

  assign bus.instr_readdata = mem_word(bus.instr_address);

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_out, m_pcout, m_cnt;
  logic        m_valid, m_active, m_fault;
  bit          m_stopped;    // halted or faulted: no more fetches
  bit          m_fault_pend; // stop was caused by a misaligned target

  task automatic model_edge();
    logic taken;
    if (reset) begin
      m_pc = RV; m_out = 0; m_pcout = 0; m_cnt = 0;
      m_valid = 0; m_active = 1; m_fault = 0;
      m_stopped = 0; m_fault_pend = 0;
    end else if (clk_enable) begin
      if (m_stopped) begin
        m_valid  = 0;
        m_active = 0;
        if (m_fault_pend) m_fault = 1;
      end else begin
        taken   = bus.redirect_valid && m_valid;
        m_out   = mem_word(m_pc);
        m_pcout = m_pc;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
        if (!taken) m_pc = m_pc + 4;
        else if (bus.redirect_target == HALTA) m_stopped = 1;
`ifdef IFU_ALIGN_CHECK_EN
        else if (bus.redirect_target[1:0] != 2'b00) begin
          m_stopped = 1; m_fault_pend = 1;
        end
`endif
        else m_pc = bus.redirect_target & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic snap_t dut_snap();
    return {bus.instr_address, bus.instr_out, bus.pc_out, fetch_count,
            bus.instr_valid, active, align_fault};
  endfunction

  function automatic snap_t model_snap();
    return {m_pc, m_out, m_pcout, m_cnt, m_valid, m_active, m_fault};
  endfunction

  task automatic drive(input logic rst, input logic en, input logic rv, input logic [31:0] rt);
    reset = rst; clk_enable = en; bus.redirect_valid = rv; bus.redirect_target = rt;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1, 1, 1, $urandom);
    tick(); tick();
    checks++;
    if (dut_snap() !== model_snap()) begin
      errors++; $display("FAIL reset_model got %h want %h", dut_snap(), model_snap());
    end
    checks++;
    if ({bus.instr_address, bus.instr_valid, active, align_fault, fetch_count, bus.pc_out} !==
        {RV, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values got addr=%h v=%b act=%b af=%b cnt=%0d pc_out=%h want addr=%h v=0 act=1 af=0 cnt=0 pc_out=0",
               bus.instr_address, bus.instr_valid, active, align_fault, fetch_count, bus.pc_out, RV);
    end
  endtask

  task automatic test_sequential();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_snap() !== model_snap()) begin
        errors++; $display("FAIL seq_model[%0d] got %h want %h", i, dut_snap(), model_snap());
      end
      checks++;
      if ({bus.pc_out, bus.instr_out, bus.instr_address} !==
          {RV + 32'(4*i), 32'h8C000000 + 32'(i), RV + 32'(4*(i+1))}) begin
        errors++;
        $display("FAIL seq_fetch[%0d] got pc_out=%h out=%h addr=%h want pc_out=%h out=%h addr=%h", i,
                 bus.pc_out, bus.instr_out, bus.instr_address,
                 RV + 32'(4*i), 32'h8C000000 + 32'(i), RV + 32'(4*(i+1)));
      end
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++; $display("FAIL seq_count got %0d want 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] addr0, cnt0;
    addr0 = bus.instr_address;
    cnt0  = fetch_count;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1'($urandom), RV + 32'h300);
      tick();
      checks++;
      if (dut_snap() !== model_snap()) begin
        errors++; $display("FAIL stall_model[%0d] got %h want %h", i, dut_snap(), model_snap());
      end
    end
    checks++;
    if ({bus.instr_address, fetch_count} !== {addr0, cnt0}) begin
      errors++; $display("FAIL stall_hold got addr=%h cnt=%0d want addr=%h cnt=%0d",
                         bus.instr_address, fetch_count, addr0, cnt0);
    end
    drive(0, 1, 0, 0);
    tick();
    checks++;
    if ({bus.pc_out, fetch_count} !== {addr0, cnt0 + 32'd1}) begin
      errors++; $display("FAIL stall_resume got pc_out=%h cnt=%0d want pc_out=%h cnt=%0d",
                         bus.pc_out, fetch_count, addr0, cnt0 + 32'd1);
    end
  endtask

  task automatic test_jump();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 64 && m_pcout != RV + 32'h10; i++) tick();
    checks++;
    if (bus.pc_out !== RV + 32'h10) begin
      errors++; $display("FAIL jump_setup got pc_out=%h want %h", bus.pc_out, RV + 32'h10);
    end
    drive(0, 1, 1, RV + 32'h100);
    tick();
    drive(0, 1, 0, 0);
    checks++;
    if ({bus.pc_out, bus.instr_valid, bus.instr_address} !== {RV + 32'h14, 1'b1, RV + 32'h100}) begin
      errors++; $display("FAIL jump_delay_slot got pc_out=%h v=%b addr=%h want pc_out=%h v=1 addr=%h",
                         bus.pc_out, bus.instr_valid, bus.instr_address, RV + 32'h14, RV + 32'h100);
    end
    tick();
    checks++;
    if ({bus.pc_out, bus.instr_out} !== {RV + 32'h100, 32'h8C000040}) begin
      errors++; $display("FAIL jump_target got pc_out=%h out=%h want pc_out=%h out=8c000040",
                         bus.pc_out, bus.instr_out, RV + 32'h100);
    end
  endtask

  task automatic test_misaligned();
    drive(0, 1, 1, RV + 32'h102);
    tick();
    drive(0, 1, 0, 0);
    checks++;
    if ({bus.pc_out, bus.instr_valid} !== {RV + 32'h104, 1'b1}) begin
      errors++; $display("FAIL misalign_slot got pc_out=%h v=%b want pc_out=%h v=1",
                         bus.pc_out, bus.instr_valid, RV + 32'h104);
    end
    tick();
    checks++;
    if (dut_snap() !== model_snap()) begin
      errors++; $display("FAIL misalign_model got %h want %h", dut_snap(), model_snap());
    end
`ifdef IFU_ALIGN_CHECK_EN
    checks++;
    if ({align_fault, active, bus.instr_valid, bus.pc_out} !== {1'b1, 1'b0, 1'b0, RV + 32'h104}) begin
      errors++; $display("FAIL misalign_fault got af=%b act=%b v=%b pc_out=%h want af=1 act=0 v=0 pc_out=%h",
                         align_fault, active, bus.instr_valid, bus.pc_out, RV + 32'h104);
    end
`else
    checks++;
    if ({align_fault, active, bus.pc_out} !== {1'b0, 1'b1, RV + 32'h100}) begin
      errors++; $display("FAIL misalign_forced got af=%b act=%b pc_out=%h want af=0 act=1 pc_out=%h",
                         align_fault, active, bus.pc_out, RV + 32'h100);
    end
`endif
  endtask

  task automatic test_halt();
    logic [31:0] cnt0;
    drive(1, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 64 && m_pcout != RV + 32'h70; i++) tick();
    drive(0, 1, 1, HALTA);
    tick();
    drive(0, 1, 0, 0);
    checks++;
    if ({bus.pc_out, bus.instr_valid, active} !== {RV + 32'h74, 1'b1, 1'b1}) begin
      errors++; $display("FAIL halt_slot got pc_out=%h v=%b act=%b want pc_out=%h v=1 act=1",
                         bus.pc_out, bus.instr_valid, active, RV + 32'h74);
    end
    cnt0 = fetch_count;
    tick();
    checks++;
    if ({bus.instr_valid, active} !== 2'b00) begin
      errors++; $display("FAIL halt_stop got v=%b act=%b want v=0 act=0", bus.instr_valid, active);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom), 1'(i % 2), RV + 32'h200);
      tick();
    end
    checks++;
    if ({bus.pc_out, bus.instr_address, fetch_count, bus.instr_valid, active} !==
        {RV + 32'h74, RV + 32'h74, cnt0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_frozen got pc_out=%h addr=%h cnt=%0d v=%b act=%b want pc_out=%h addr=%h cnt=%0d v=0 act=0",
                         bus.pc_out, bus.instr_address, fetch_count, bus.instr_valid, active,
                         RV + 32'h74, RV + 32'h74, cnt0);
    end
  endtask

  task automatic test_reset_redirect();
    drive(1, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0);
    repeat (4) tick();
    drive(1, 1, 1, RV + 32'h200);
    tick();
    checks++;
    if ({bus.instr_address, bus.instr_valid, fetch_count} !== {RV, 1'b0, 32'd0}) begin
      errors++; $display("FAIL rst_redirect got addr=%h v=%b cnt=%0d want addr=%h v=0 cnt=0",
                         bus.instr_address, bus.instr_valid, fetch_count, RV);
    end
    drive(0, 1, 0, 0);
    tick();
    checks++;
    if ({bus.pc_out, bus.instr_address} !== {RV, RV + 32'h4}) begin
      errors++; $display("FAIL rst_redirect_lost got pc_out=%h addr=%h want pc_out=%h addr=%h",
                         bus.pc_out, bus.instr_address, RV, RV + 32'h4);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    drive(1, 1, 0, 0);
    tick();
    for (int i = 0; i < 600; i++) begin
      tgt = RV + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 15) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 79) == 0) tgt = HALTA;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, tgt);
      tick();
      checks++;
      if (dut_snap() !== model_snap()) begin
        errors++; $display("FAIL random[%0d] got %h want %h", i, dut_snap(), model_snap());
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0);
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_misaligned();
    test_halt();
    test_reset_redirect();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
